// File: rtl/layer7_weight_reader_if.sv
// Control, memory-read and weight-stream signals of the layer-7 weight reader.
// The master modport is the reader's view; the slave modport is the environment's.
interface layer7_weight_reader_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned WORD_W = LANES * DATA_W;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 6;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;

  logic              read_weight_signal;
  logic [ADDR_W-1:0] read_weight_addr1;
  logic [ADDR_W-1:0] read_weight_addr2;
  logic [WORD_W-1:0] read_weight_data1;
  logic [WORD_W-1:0] read_weight_data2;

  logic              weight_valid;
  logic              weight_ready;
  logic [DATA_W-1:0] weight_data1;
  logic [DATA_W-1:0] weight_data2;

  modport master (
    input  start, base_addr, word_count,
    input  read_weight_data1, read_weight_data2,
    input  weight_ready,
    output busy, done,
    output read_weight_signal, read_weight_addr1, read_weight_addr2,
    output weight_valid, weight_data1, weight_data2
  );

  modport slave (
    output start, base_addr, word_count,
    output read_weight_data1, read_weight_data2,
    output weight_ready,
    input  busy, done,
    input  read_weight_signal, read_weight_addr1, read_weight_addr2,
    input  weight_valid, weight_data1, weight_data2
  );
endinterface

// File: rtl/layer7_weight_reader.sv
// Reads a block of 128-bit words from both layer-7 weight ports and streams
// them lane 0 first as 16-bit weight pairs over a valid/ready handshake.
module layer7_weight_reader #(
  parameter int unsigned LANES     = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_WORDS = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  layer7_weight_reader_if.master bus
);
  localparam int unsigned WORD_W = LANES * DATA_W;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned IDX_W  = $clog2(MAX_WORDS + 1);
  localparam int unsigned LANE_W = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WORD_W-1:0]   cap1_q, cap1_d;
  logic [WORD_W-1:0]   cap2_q, cap2_d;

  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   w1_q, w1_d;
  logic [DATA_W-1:0]   w2_q, w2_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    cnt_clamped;
  logic                xfer;

  assign cnt_clamped = (bus.word_count > CNT_W'(MAX_WORDS)) ? IDX_W'(MAX_WORDS)
                                                            : IDX_W'(bus.word_count);
  assign xfer = valid_q && bus.weight_ready;

  // Next state, capture registers and block bookkeeping
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base_addr;
          cnt_d   = cnt_clamped;
          idx_d   = '0;
          state_d = (bus.word_count == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        // Memory answers on the falling edge, so the word is stable here.
        cap1_d  = bus.read_weight_data1;
        cap2_d  = bus.read_weight_data2;
        lane_d  = '0;
        state_d = STREAM;
      end
      STREAM: begin
        if (xfer) begin
          if (lane_q != LANE_W'(LANES - 1)) begin
            lane_d = lane_q + LANE_W'(1);
          end else if ((idx_q + IDX_W'(1)) == cnt_q) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers are loaded from the next-state view so they line up with state
  always_comb begin
    rd_d    = (state_d == FETCH);
    addr_d  = rd_d ? ADDR_W'(base_d + ADDR_W'(idx_d)) : '0;
    valid_d = (state_d == STREAM);
    w1_d    = valid_d ? cap1_d[int'(lane_d) * DATA_W +: DATA_W] : '0;
    w2_d    = valid_d ? cap2_d[int'(lane_d) * DATA_W +: DATA_W] : '0;
    busy_d  = (state_d == FETCH) || (state_d == STREAM);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      cap1_q  <= '0;
      cap2_q  <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.read_weight_signal = rd_q;
  assign bus.read_weight_addr1  = addr_q;
  assign bus.read_weight_addr2  = addr_q;
  assign bus.weight_valid       = valid_q;
  assign bus.weight_data1       = w1_q;
  assign bus.weight_data2       = w2_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
endmodule

// File: tb/tb_layer7_weight_reader.sv
// Bench for layer7_weight_reader: a queue model of the expected address and
// weight-pair stream, checked every cycle, plus literal anchor values.
module tb_layer7_weight_reader;
  localparam int unsigned LANES     = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MAX_WORDS = 25;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  layer7_weight_reader_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  layer7_weight_reader #(.LANES(LANES), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [127:0] mem [256];

  // Falling-edge memory; port 2 sits 25 words above port 1
  always @(negedge clk) begin
    if (bus.read_weight_signal) begin
      bus.read_weight_data1 <= mem[bus.read_weight_addr1[7:0]];
      bus.read_weight_data2 <= mem[8'(bus.read_weight_addr2[7:0] + 8'd25)];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] q_addr [$];
  logic [31:0] q_pair [$];
  bit          active    = 1'b0;
  bit          done_now  = 1'b0;
  int          avail     = 0;

  int          fetches, transfers, dones, first_fetch, last_xfer, done_cyc, start_cyc;
  bit          have_first;
  logic [31:0] first_pair, last_pair;
  logic [15:0] first_addr;

  bit          start_req = 1'b0;
  bit          arm_start_at_done = 1'b0;
  bit          use_pat = 1'b0;
  bit          ready_lvl = 1'b1;
  logic [15:0] req_base = '0;
  logic [5:0]  req_cnt = '0;
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lane_of(input logic [127:0] w, input int l);
    return w[l*16 +: 16];
  endfunction

  task automatic clr_stats();
    fetches = 0; transfers = 0; dones = 0;
    first_fetch = -1; last_xfer = -1; done_cyc = -1; start_cyc = -1;
    have_first = 1'b0; first_pair = '0; last_pair = '0; first_addr = '0;
  endtask

  // One clock: check outputs against the model, then drive inputs for the next edge
  task automatic step();
    bit          cur_active, nxt_done, fire;
    logic [15:0] a;
    int          n;
    @(negedge clk);
    cyc++;
    if (rst) begin
      chk("done", 128'(bus.done), 128'(done_now));
      chk("busy", 128'(bus.busy), 128'(active && !done_now));
      chk("valid", 128'(bus.weight_valid), 128'(avail > 0));
      if (bus.weight_valid) begin
        chk("pair_pending", 128'(q_pair.size() != 0), 128'(1));
        if (q_pair.size() != 0) begin
          chk("pair", 128'({bus.weight_data1, bus.weight_data2}), 128'(q_pair[0]));
          if (!have_first) begin
            first_pair = {bus.weight_data1, bus.weight_data2};
            have_first = 1'b1;
          end
        end
      end else begin
        chk("data_idle", 128'({bus.weight_data1, bus.weight_data2}), 128'(0));
      end
      if (bus.read_weight_signal) begin
        chk("addr_pending", 128'(q_addr.size() != 0), 128'(1));
        if (q_addr.size() != 0) begin
          chk("addr1", 128'(bus.read_weight_addr1), 128'(q_addr[0]));
          chk("addr2", 128'(bus.read_weight_addr2), 128'(q_addr[0]));
          void'(q_addr.pop_front());
        end
        if (fetches == 0) begin
          first_fetch = cyc;
          first_addr  = bus.read_weight_addr1;
        end
        fetches++;
        avail += int'(LANES);
      end else begin
        chk("addr_idle", 128'({bus.read_weight_addr1, bus.read_weight_addr2}), 128'(0));
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end
    end

    cur_active = active;
    nxt_done   = 1'b0;
    if (done_now) active = 1'b0;

    bus.weight_ready = use_pat ? pat[cyc % 4] : ready_lvl;
    if (rst && bus.weight_valid && bus.weight_ready && q_pair.size() != 0) begin
      last_pair = q_pair.pop_front();
      avail--;
      transfers++;
      last_xfer = cyc;
      if (q_pair.size() == 0 && q_addr.size() == 0) nxt_done = 1'b1;
    end

    fire = start_req || (arm_start_at_done && done_now);
    if (fire) begin
      start_req = 1'b0;
      arm_start_at_done = 1'b0;
      start_cyc = cyc;
    end
    bus.start      = fire;
    bus.base_addr  = req_base;
    bus.word_count = req_cnt;
    if (rst && fire && !cur_active) begin
      n = (req_cnt > 6'(MAX_WORDS)) ? int'(MAX_WORDS) : int'(req_cnt);
      for (int w = 0; w < n; w++) begin
        a = 16'(req_base + 16'(w));
        q_addr.push_back(a);
        for (int l = 0; l < int'(LANES); l++)
          q_pair.push_back({lane_of(mem[a[7:0]], l), lane_of(mem[8'(a[7:0] + 8'd25)], l)});
      end
      active = 1'b1;
      if (n == 0) nxt_done = 1'b1;
    end
    done_now = nxt_done;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dones == 0; i++) step();
    repeat (3) step();
  endtask

  task automatic run_block(input logic [15:0] base, input logic [5:0] cnt, input int budget);
    clr_stats();
    req_base  = base;
    req_cnt   = cnt;
    start_req = 1'b1;
    wait_done(budget);
    chk("done_once", 128'(dones), 128'(1));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {bus.weight_valid, bus.busy, bus.done, bus.read_weight_signal,
               bus.read_weight_addr1, bus.read_weight_addr2,
               bus.weight_data1, bus.weight_data2}, 128'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.weight_ready = 1'b0;
    for (int i = 0; i < 256; i++)
      for (int l = 0; l < 8; l++)
        mem[i][l*16 +: 16] = 16'(i * 16 + l) ^ 16'hA500;
    for (int l = 0; l < 8; l++) begin
      mem[3][l*16 +: 16]  = 16'(16'h0001 + 16'(l));
      mem[28][l*16 +: 16] = 16'(16'h0101 + 16'(l));
    end
    clr_stats();

    #1;
    chk_all_zero("reset_outputs");
    step();
    step();
    rst = 1'b1;

    // Single word, ready held high
    use_pat = 1'b0;
    ready_lvl = 1'b1;
    run_block(16'd3, 6'd1, 60);
    chk("single_addr", 128'(first_addr), 128'(16'd3));
    chk("single_first_pair", 128'(first_pair), 128'(32'h0001_0101));
    chk("single_last_pair", 128'(last_pair), 128'(32'h0008_0108));
    chk("single_transfers", 128'(transfers), 128'(8));
    chk("single_span", 128'(last_xfer - first_fetch + 1), 128'(9));
    chk("single_done_lat", 128'(done_cyc - last_xfer), 128'(1));

    // Backpressure 1,0,0,1 plus a start raised in the done cycle
    use_pat = 1'b1;
    clr_stats();
    req_base = 16'd3;
    req_cnt = 6'd1;
    start_req = 1'b1;
    for (int i = 0; i < 80 && dones == 0; i++) step();
    arm_start_at_done = 1'b1;
    for (int i = 0; i < 5 && dones == 0; i++) step();
    repeat (6) step();
    chk("bp_done_once", 128'(dones), 128'(1));
    chk("bp_transfers", 128'(transfers), 128'(8));
    chk("bp_fetches", 128'(fetches), 128'(1));
    chk("bp_first_pair", 128'(first_pair), 128'(32'h0001_0101));
    chk("bp_last_pair", 128'(last_pair), 128'(32'h0008_0108));
    arm_start_at_done = 1'b0;
    use_pat = 1'b0;

    // Full 25-word block
    run_block(16'd0, 6'd25, 400);
    chk("multi_first_addr", 128'(first_addr), 128'(16'd0));
    chk("multi_fetches", 128'(fetches), 128'(25));
    chk("multi_transfers", 128'(transfers), 128'(200));
    chk("multi_span", 128'(last_xfer - first_fetch + 1), 128'(225));

    // Zero count
    run_block(16'd7, 6'd0, 20);
    chk("zero_fetches", 128'(fetches), 128'(0));
    chk("zero_transfers", 128'(transfers), 128'(0));
    chk("zero_done_lat", 128'(done_cyc - start_cyc), 128'(1));

    // Oversized count clamps to 25 words
    run_block(16'd0, 6'd40, 400);
    chk("clamp_fetches", 128'(fetches), 128'(25));
    chk("clamp_transfers", 128'(transfers), 128'(200));

    // Start while busy is ignored
    clr_stats();
    req_base = 16'd5;
    req_cnt = 6'd3;
    start_req = 1'b1;
    repeat (12) step();
    req_base = 16'd10;
    req_cnt = 6'd2;
    start_req = 1'b1;
    wait_done(100);
    chk("busy_start_done", 128'(dones), 128'(1));
    chk("busy_start_first_addr", 128'(first_addr), 128'(16'd5));
    chk("busy_start_fetches", 128'(fetches), 128'(3));
    chk("busy_start_transfers", 128'(transfers), 128'(24));

    // Asynchronous reset while lane 4 is presented
    clr_stats();
    req_base = 16'd3;
    req_cnt = 6'd1;
    start_req = 1'b1;
    for (int i = 0; i < 40 && transfers < 5; i++) step();
    chk("mid_lane4_pair", 128'(last_pair), 128'(32'h0005_0105));
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_reset_outputs");
    q_addr.delete();
    q_pair.delete();
    active = 1'b0;
    done_now = 1'b0;
    avail = 0;
    dones = 0;
    step();
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("mid_no_done", 128'(dones), 128'(0));
    run_block(16'd3, 6'd1, 60);
    chk("restart_first_pair", 128'(first_pair), 128'(32'h0001_0101));
    chk("restart_transfers", 128'(transfers), 128'(8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
